// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Run-time choice of fixed-select or round-robin arbitration.
module rr_stream_mux #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic                         mode,
   input  logic [SEL_W-1:0]             sel,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SEL_W-1:0]             out_chan
);

   localparam int unsigned IDX_W = SEL_W + 1;

   logic [SEL_W-1:0]    rr_ptr;
   logic [CHANNELS-1:0] grant_c;
   logic [SEL_W-1:0]    grant_idx_c;
   logic                grant_any_c;
   logic [WIDTH-1:0]    grant_data_c;
   logic [IDX_W-1:0]    scan_idx_c;
   logic                load_en_c;
   logic                xfer_c;

   // Arbitration: direct select in mode 0, rotating priority from rr_ptr in mode 1.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      grant_any_c = 1'b0;
      scan_idx_c  = '0;
      if (!mode) begin
         // Comparing against every legal index naturally rejects sel >= CHANNELS.
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
               grant_c[k]  = 1'b1;
               grant_idx_c = SEL_W'(k);
               grant_any_c = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            scan_idx_c = IDX_W'(rr_ptr) + IDX_W'(i);
            if (scan_idx_c >= IDX_W'(CHANNELS)) begin
               scan_idx_c = scan_idx_c - IDX_W'(CHANNELS);
            end
            if (!grant_any_c && in_valid[scan_idx_c[SEL_W-1:0]]) begin
               grant_c[scan_idx_c[SEL_W-1:0]] = 1'b1;
               grant_idx_c = scan_idx_c[SEL_W-1:0];
               grant_any_c = 1'b1;
            end
         end
      end
   end

   // Data of the granted channel.
   always_comb begin
      grant_data_c = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (grant_c[k]) begin
            grant_data_c = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // No skid buffer: the output register accepts only when empty or draining.
   assign load_en_c = !out_valid || out_ready;
   assign xfer_c    = rst_n && load_en_c && grant_any_c;
   assign in_ready  = (rst_n && load_en_c) ? grant_c : '0;

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= '0;
      end else if (xfer_c) begin
         out_data  <= grant_data_c;
         out_chan  <= grant_idx_c;
         out_valid <= 1'b1;
         if (mode) begin
            rr_ptr <= (grant_idx_c == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx_c + SEL_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomised and directed bench for rr_stream_mux against a behavioural model.
// A second 3-channel instance covers the non-power-of-two wrap and out-of-range select.
module tb_rr_stream_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_chan;

   logic [23:0] d3_in_data;
   logic [2:0]  d3_in_valid;
   logic [2:0]  d3_in_ready;
   logic        d3_mode;
   logic [1:0]  d3_sel;
   logic [7:0]  d3_out_data;
   logic        d3_out_valid;
   logic        d3_out_ready;
   logic [1:0]  d3_out_chan;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // behavioural model state
   int m_ptr, m_data, m_chan;
   bit m_valid;

   always #5 clk = ~clk;

   rr_stream_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
   );

   rr_stream_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
      .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_chan(d3_out_chan)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Winner under the arbitration rules, or -1 when nothing is granted.
   function automatic int model_grant();
      if (!mode) begin
         if (int'(sel) < 4 && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int i = 0; i < 4; i++) begin
         if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_data = 0; m_chan = 0; m_valid = 1'b0;
   endtask

   // One clock: entered and left at a falling edge with inputs already driven.
   task automatic step();
      int g, n_ptr, n_data, n_chan;
      bit load, n_valid;
      #1;
      g    = model_grant();
      load = !m_valid || out_ready;
      check("in_ready", 32'(in_ready), (load && g >= 0) ? (32'd1 << g) : 32'd0);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_chan", 32'(out_chan), 32'(m_chan));
      n_ptr = m_ptr; n_data = m_data; n_chan = m_chan; n_valid = m_valid;
      if (load && g >= 0) begin
         n_data = int'(in_data[g*8 +: 8]); n_chan = g; n_valid = 1'b1;
         if (mode) n_ptr = (g + 1) % 4;
      end else if (out_ready) begin
         n_valid = 1'b0;
      end
      @(posedge clk);
      m_ptr = n_ptr; m_data = n_data; m_chan = n_chan; m_valid = n_valid;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fixed_data();
      for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
   endtask

   initial begin
      logic [7:0] held;
      rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      d3_in_data = {8'hB2, 8'hB1, 8'hB0}; d3_in_valid = 3'b111; d3_mode = 1'b1;
      d3_sel = 2'd0; d3_out_ready = 1'b1;
      model_reset();
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      rst_n = 1'b1;

      // Test 1: asynchronous reset with a word held
      fixed_data(); in_valid = 4'hF; mode = 1'b1; out_ready = 1'b1;
      repeat (3) step();
      check("t1_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t1_valid", 32'(out_valid), 32'd0);
      check("t1_data", 32'(out_data), 32'd0);
      check("t1_chan", 32'(out_chan), 32'd0);
      check("t1_in_ready", 32'(in_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t1_first_rr", 32'(out_chan), 32'd0);

      // Test 2: fixed select of channel 2
      mode = 1'b0; sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_data", 32'(out_data), 32'hA2);
         check("t2_chan", 32'(out_chan), 32'd2);
         check("t2_in_ready", 32'(in_ready), 32'b0100);
      end

      // Test 3: round-robin over all valid channels
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_data", 32'(out_data), 32'hA0 + 32'(i % 4));
         check("t3_chan", 32'(out_chan), 32'(i % 4));
      end

      // Test 4: sparse valid, plus the 3-channel wrap
      do_reset();
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_chan", 32'(out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
         check("t4_ch3_chan", 32'(d3_out_chan), 32'(i % 3));
         check("t4_ch3_data", 32'(d3_out_data), 32'hB0 + 32'(i % 3));
      end

      // Test 5: backpressure for three cycles
      do_reset();
      in_valid = 4'hF;
      step();
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_in_ready", 32'(in_ready), 32'd0);
         check("t5_hold", 32'(out_data), 32'(held));
         check("t5_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("t5_reload_ready", 32'(in_ready), 32'b0010);
      step();
      check("t5_next", 32'(out_data), 32'hA1);

      // Test 6: no grant in fixed mode; pointer untouched
      do_reset();
      step();
      mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
      d3_mode = 1'b0; d3_sel = 2'd3;
      step();
      step();
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_ch3_valid", 32'(d3_out_valid), 32'd0);
      check("t6_ch3_in_ready", 32'(d3_in_ready), 32'd0);
      mode = 1'b1; in_valid = 4'hF;
      step();
      check("t6_ptr_kept", 32'(out_chan), 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_data   = $urandom;
         in_valid  = 4'($urandom);
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         if (i == 200) begin
            do_reset();
         end
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
